// File: rtl/processor_core.sv
// Single-cycle 32-bit register machine: 512-word instruction memory loaded while idle,
// 16-entry register file, one instruction retired per clock while working is high.
module processor_core (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [8:0]  addr,
    input  logic        wEn,
    input  logic [31:0] wDat,
    input  logic        working,
    input  logic [3:0]  rID,
    output logic [31:0] rdata
);

    localparam logic [7:0] OpIrmov = 8'h10;
    localparam logic [7:0] OpAdd   = 8'h20;
    localparam logic [7:0] OpSub   = 8'h21;
    localparam logic [7:0] OpAnd   = 8'h32;

    logic [31:0] r_mem [512];
    logic [31:0] r_regs [16];
    logic [8:0]  r_pc;

    logic [31:0] w_instr;
    logic [7:0]  w_op;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [15:0] w_imm;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_wr_en;
    logic [3:0]  w_wr_idx;
    logic [31:0] w_wr_val;

    assign w_instr = r_mem[r_pc];
    assign w_op    = w_instr[31:24];
    assign w_ra    = w_instr[23:20];
    assign w_rb    = w_instr[19:16];
    assign w_imm   = w_instr[15:0];
    assign w_a     = r_regs[w_ra];
    assign w_b     = r_regs[w_rb];

    always_comb begin
        w_wr_en  = 1'b1;
        w_wr_idx = w_ra;
        w_wr_val = 32'd0;
        case (w_op)
            OpIrmov: begin
                w_wr_idx = w_rb;
                w_wr_val = {16'd0, w_imm};
            end
            OpAdd:   w_wr_val = w_a + w_b;
            OpSub:   w_wr_val = w_a - w_b;
            OpAnd:   w_wr_val = w_a & w_b;
            default: w_wr_en  = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_pc <= 9'd0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (working) begin
            r_pc <= r_pc + 9'd1;
            if (w_wr_en) begin
                r_regs[w_wr_idx] <= w_wr_val;
            end
        end
    end

    // Instruction memory is not cleared by reset; reset only blocks the write.
    always_ff @(posedge clock) begin
        if (rst_n && !working && wEn) begin
            r_mem[addr] <= wDat;
        end
    end

    assign rdata = r_regs[rID];

endmodule

// File: tb/tb_processor_core.sv
// Directed bench for processor_core: program table load, register table checks,
// plus halt/resume, write lockout, PC wrap and mid-run reset sequences.
module tb_processor_core;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [8:0]  addr;
    logic        wEn;
    logic [31:0] wDat;
    logic        working;
    logic [3:0]  rID;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [8:0]  a;
        logic [31:0] instr;
    } prog_t;

    typedef struct {
        logic [3:0]  rid;
        logic [31:0] exp;
    } vec_t;

    prog_t prog [10];
    vec_t  final_vec [16];

    processor_core dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .addr    (addr),
        .wEn     (wEn),
        .wDat    (wDat),
        .working (working),
        .rID     (rID),
        .rdata   (rdata)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        working = 1'b1;
        for (int i = 0; i < n; i++) tick();
        working = 1'b0;
    endtask

    task automatic write_mem(input logic [8:0] a, input logic [31:0] d);
        addr = a;
        wDat = d;
        wEn  = 1'b1;
        tick();
        wEn  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_reg(input string name, input logic [3:0] r, input logic [31:0] exp);
        rID = r;
        #1;
        total++;
        if (rdata !== exp) begin
            bad++;
            $display("FAIL %s r%0d: got 0x%08h expected 0x%08h", name, r, rdata, exp);
        end
    endtask

    task automatic chk_final(input string name);
        for (int i = 0; i < 16; i++) chk_reg(name, final_vec[i].rid, final_vec[i].exp);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 10; i++) write_mem(prog[i].a, prog[i].instr);
    endtask

    initial begin
        prog[0] = '{9'd0, 32'h1000001C};
        prog[1] = '{9'd1, 32'h1001001D};
        prog[2] = '{9'd2, 32'h1002001E};
        prog[3] = '{9'd3, 32'h1003001F};
        prog[4] = '{9'd4, 32'h10040020};
        prog[5] = '{9'd5, 32'h10050021};
        prog[6] = '{9'd6, 32'h20010000};
        prog[7] = '{9'd7, 32'h21230000};
        prog[8] = '{9'd8, 32'h32450000};
        prog[9] = '{9'd9, 32'h20100000};
        for (int i = 0; i < 16; i++) final_vec[i] = '{i[3:0], 32'd0};
        final_vec[0].exp = 32'h39;
        final_vec[1].exp = 32'h56;
        final_vec[2].exp = 32'hFFFFFFFF;
        final_vec[3].exp = 32'h1F;
        final_vec[4].exp = 32'h20;
        final_vec[5].exp = 32'h21;

        rst_n = 1'b1; addr = '0; wEn = 1'b0; wDat = '0; working = 1'b0; rID = '0;
        tick();

        // Clear memory explicitly so the bench does not rely on power-up contents.
        for (int i = 0; i < 512; i++) write_mem(i[8:0], 32'd0);
        do_reset();
        for (int i = 0; i < 16; i++) chk_reg("reset", i[3:0], 32'd0);

        // Load and run, holding a locked-out write to address 10 throughout.
        load_prog();
        addr = 9'd10; wDat = 32'h10070055; wEn = 1'b1;
        run(13);
        wEn = 1'b0;
        chk_final("run");

        // Halt after three IRMOVs, then resume.
        do_reset();
        for (int i = 0; i < 16; i++) chk_reg("rerst", i[3:0], 32'd0);
        run(3);
        chk_reg("halt", 4'd0, 32'h1C);
        chk_reg("halt", 4'd1, 32'h1D);
        chk_reg("halt", 4'd2, 32'h1E);
        chk_reg("halt", 4'd3, 32'h0);
        tick();
        tick();
        chk_reg("frozen", 4'd3, 32'h0);
        run(10);
        chk_final("resume");

        // Mid-run reset with a concurrent memory write that reset must block.
        do_reset();
        run(5);
        working = 1'b1;
        rst_n = 1'b0;
        tick();
        working = 1'b0;
        addr = 9'd12; wDat = 32'h10090077; wEn = 1'b1;
        tick();
        wEn = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) chk_reg("midrst", i[3:0], 32'd0);
        run(13);
        chk_final("rerun");

        // Wrap: only address 511 holds an instruction.
        for (int i = 0; i < 10; i++) write_mem(i[8:0], 32'd0);
        write_mem(9'd511, 32'h10060007);
        do_reset();
        run(512);
        chk_reg("wrap", 4'd6, 32'h7);
        chk_reg("wrap", 4'd0, 32'h0);
        write_mem(9'd0, 32'h10080099);
        run(1);
        chk_reg("pc0", 4'd8, 32'h99);
        run(511);
        chk_reg("wrap2", 4'd6, 32'h7);
        chk_reg("wrap2", 4'd8, 32'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
